ws2812_rx: RTL and testbench

WS2812_RX -- requirements
Module: ws2812_rx

---
 rtl/ws2812_pkg.sv | 15 +
 rtl/ws2812_rx_sync.sv | 42 ++++
 rtl/ws2812_rx.sv | 158 +++++++++++++++
 tb/tb_ws2812_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared types and default timing constants for the WS2812 receiver.
package ws2812_pkg;

    typedef enum logic [1:0] {
        WAIT_GAP,
        IDLE,
        HIGH,
        LOW
    } state_t;

    localparam int WORD_W       = 24;
    localparam int DEF_T_THRESH = 7;
    localparam int DEF_T_RESET  = 600;

endpackage

// File: rtl/ws2812_rx_sync.sv
// Two-flop synchronizer for the WS2812 line, optionally followed by a
// registered 3-sample majority filter (WS2812_RX_GLITCH_FILTER_EN).
module ws2812_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic line
);

    logic s1, s2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

`ifdef WS2812_RX_GLITCH_FILTER_EN
    logic [1:0] hist;
    logic       filt;

    // Registered majority vote: two extra cycles on both edges, so pulse widths are kept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hist <= '0;
            filt <= 1'b0;
        end else begin
            hist <= {hist[0], s2};
            filt <= (s2 & hist[0]) | (s2 & hist[1]) | (hist[0] & hist[1]);
        end
    end

    assign line = filt;
`else
    assign line = s2;
`endif

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 serial receiver: decodes 24-bit words by high-pulse width and
// numbers them per latch-delimited frame. Optional WS2812_RX_GLITCH_FILTER_EN.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int T_THRESH = DEF_T_THRESH,
    parameter int T_RESET  = DEF_T_RESET
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din,
    output logic [WORD_W-1:0] rgb_data,
    output logic [7:0]        led_num,
    output logic              valid,
    output logic              frame_done,
    output logic              err
);

    localparam int CW = $clog2(T_RESET + 1);
    localparam int BW = $clog2(WORD_W);

    state_t            state, state_n;
    logic              line, line_d, rise, fall, bitv;
    logic [CW-1:0]     high_cnt, high_n, low_cnt, low_n, high_inc, low_inc;
    logic [BW-1:0]     bit_cnt, bits_n;
    logic [WORD_W-2:0] shift, shift_n;
    logic [7:0]        idx, idx_n, led_n;
    logic [WORD_W-1:0] rgb_n;
    logic              valid_n, done_n, err_n;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CW'(T_RESET)) ? c : c + CW'(1);
    endfunction

    ws2812_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .line  (line)
    );

    assign rise     = line & ~line_d;
    assign fall     = ~line & line_d;
    assign bitv     = (high_cnt >= CW'(T_THRESH));
    assign high_inc = sat_inc(high_cnt);
    assign low_inc  = sat_inc(low_cnt);

    always_comb begin
        state_n = state;
        high_n  = high_cnt;
        low_n   = low_cnt;
        bits_n  = bit_cnt;
        shift_n = shift;
        idx_n   = idx;
        rgb_n   = rgb_data;
        led_n   = led_num;
        valid_n = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            WAIT_GAP: begin
                if (line) begin
                    low_n = '0;
                end else if (low_inc == CW'(T_RESET)) begin
                    low_n   = '0;
                    state_n = IDLE;
                end else begin
                    low_n = low_inc;
                end
            end
            IDLE: begin
                if (rise) begin
                    high_n  = CW'(1);
                    state_n = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_n = LOW;
                    low_n   = '0;
                    if (bit_cnt == BW'(WORD_W - 1)) begin
                        // Word complete: publish straight from the incoming bit, no extra shift cycle.
                        bits_n  = '0;
                        shift_n = '0;
                        if (idx < 8'(NUM_LEDS)) begin
                            valid_n = 1'b1;
                            rgb_n   = {shift, bitv};
                            led_n   = idx;
                            idx_n   = idx + 8'd1;
                        end else begin
                            err_n = 1'b1;
                        end
                    end else begin
                        shift_n = {shift[WORD_W-3:0], bitv};
                        bits_n  = bit_cnt + BW'(1);
                    end
                end else if (high_inc == CW'(T_RESET)) begin
                    err_n   = 1'b1;
                    bits_n  = '0;
                    shift_n = '0;
                    low_n   = '0;
                    state_n = WAIT_GAP;
                end else begin
                    high_n = high_inc;
                end
            end
            LOW: begin
                if (rise) begin
                    high_n  = CW'(1);
                    state_n = HIGH;
                end else if (low_inc == CW'(T_RESET)) begin
                    done_n  = 1'b1;
                    err_n   = (bit_cnt != '0);
                    idx_n   = '0;
                    bits_n  = '0;
                    shift_n = '0;
                    low_n   = '0;
                    state_n = IDLE;
                end else begin
                    low_n = low_inc;
                end
            end
            default: state_n = WAIT_GAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= WAIT_GAP;
            line_d     <= 1'b0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            idx        <= '0;
            rgb_data   <= '0;
            led_num    <= '0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            line_d     <= line;
            high_cnt   <= high_n;
            low_cnt    <= low_n;
            bit_cnt    <= bits_n;
            shift      <= shift_n;
            idx        <= idx_n;
            rgb_data   <= rgb_n;
            led_num    <= led_n;
            valid      <= valid_n;
            frame_done <= done_n;
            err        <= err_n;
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: stimulus pushes expected output events,
// a monitor pops and compares each pulse (valid / frame_done / err).
module tb_ws2812_rx;

    localparam int NUM_LEDS = 8;
    localparam int T_THRESH = 7;
    localparam int T_RESET  = 600;
`ifdef WS2812_RX_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        din = 1'b0;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        valid, frame_done, err;

    ws2812_rx #(
        .NUM_LEDS (NUM_LEDS),
        .T_THRESH (T_THRESH),
        .T_RESET  (T_RESET)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .rgb_data   (rgb_data),
        .led_num    (led_num),
        .valid      (valid),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          v;
        bit          fd;
        bit          er;
        logic [23:0] rgb;
        logic [7:0]  led;
        int          at;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model: frame position and gap state as seen from the line.
    bit          in_gap   = 1'b1;
    bit          m_active = 1'b0;
    int          m_idx    = 0;
    int          m_bits   = 0;
    logic [23:0] last_rgb = '0;
    logic [7:0]  last_led = '0;

    function automatic void push(bit v, bit fd, bit er, logic [23:0] rgb, logic [7:0] led, int at);
        ev_t e;
        e.v = v; e.fd = fd; e.er = er; e.rgb = rgb; e.led = led; e.at = at;
        q.push_back(e);
    endfunction

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endfunction

    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (valid || frame_done || err) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got v=%0b fd=%0b er=%0b rgb=%06h led=%0d at cycle %0d, required no event",
                             valid, frame_done, err, rgb_data, led_num, cyc);
                end else begin
                    e = q.pop_front();
                    if (valid !== e.v || frame_done !== e.fd || err !== e.er ||
                        rgb_data !== e.rgb || led_num !== e.led) begin
                        errors++;
                        $display("FAIL event: got v=%0b fd=%0b er=%0b rgb=%06h led=%0d, required v=%0b fd=%0b er=%0b rgb=%06h led=%0d",
                                 valid, frame_done, err, rgb_data, led_num, e.v, e.fd, e.er, e.rgb, e.led);
                    end
                    if (e.at != 0) begin
                        checks++;
                        if (cyc != e.at) begin
                            errors++;
                            $display("FAIL latency: got cycle %0d, required cycle %0d", cyc, e.at);
                        end
                    end
                end
            end
        end
    end

    task automatic bit_out(input bit b, input bit fixed, input bit last, input logic [23:0] w, input bit glitch);
        int h, l;
        if (fixed) begin
            h = b ? 10 : 5;
            l = b ? 5 : 10;
        end else begin
            h = b ? int'($urandom_range(12, 7)) : int'($urandom_range(6, 2));
            l = int'($urandom_range(12, 3));
        end
        din = 1'b1;
        repeat (h) @(negedge clk);
        din = 1'b0;
        if (!in_gap) begin
            m_bits++;
            m_active = 1'b1;
            if (last && m_bits == 24) begin
                m_bits = 0;
                if (m_idx < NUM_LEDS) begin
                    push(1'b1, 1'b0, 1'b0, w, 8'(m_idx), cyc + LAT);
                    last_rgb = w;
                    last_led = 8'(m_idx);
                    m_idx++;
                end else begin
                    push(1'b0, 1'b0, 1'b1, last_rgb, last_led, cyc + LAT);
                end
            end
        end
        if (glitch) begin
            repeat (4) @(negedge clk);
            din = 1'b1;
            @(negedge clk);
            din = 1'b0;
            repeat (5) @(negedge clk);
        end else begin
            repeat (l) @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [23:0] w, input bit fixed, input int glitch_at);
        for (int i = 23; i >= 0; i--)
            bit_out(w[i], fixed, i == 0, w, i == glitch_at);
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++)
            bit_out(1'($urandom_range(1, 0)), 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic gap(input int n);
        din = 1'b0;
        if (n >= T_RESET) begin
            if (!in_gap && m_active) begin
                push(1'b0, 1'b1, m_bits != 0, last_rgb, last_led, 0);
                m_idx    = 0;
                m_bits   = 0;
                m_active = 1'b0;
            end
            in_gap = 1'b0;
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_high(input int n);
        din = 1'b1;
        if (!in_gap && m_active)
            push(1'b0, 1'b0, 1'b1, last_rgb, last_led, 0);
        in_gap   = 1'b1;
        m_bits   = 0;
        m_active = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        din      = 1'b0;
        reset    = 1'b0;
        in_gap   = 1'b1;
        m_active = 1'b0;
        m_idx    = 0;
        m_bits   = 0;
        last_rgb = '0;
        last_led = '0;
        repeat (n) @(negedge clk);
        chk("reset_rgb_data", 32'(rgb_data), 32'h0);
        chk("reset_led_num", 32'(led_num), 32'h0);
        chk("reset_pulses", {29'b0, valid, frame_done, err}, 32'h0);
        reset = 1'b1;
    endtask

    initial begin
        logic [23:0] w;
        int          n;

        do_reset(4);
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_frame_done", 32'(frame_done), 32'h0);
        gap(T_RESET);

        // Single known word with the nominal 0/1 encodings
        send_word(24'h100000, 1'b1, -1);
        gap(T_RESET);

        // Full frame of identical words
        for (int i = 0; i < NUM_LEDS; i++) send_word(24'h001000, 1'b1, -1);
        gap(T_RESET);

        // One word beyond NUM_LEDS
        for (int i = 0; i < NUM_LEDS + 1; i++) send_word(24'($urandom()), 1'b0, -1);
        gap(T_RESET);

        // Partial word followed by a latch
        send_bits(12);
        gap(T_RESET);

        // Line stuck high mid-word, a word during the wait is ignored
        send_bits(5);
        hold_high(T_RESET);
        gap(100);
        send_word(24'($urandom()), 1'b0, -1);
        gap(T_RESET);
        send_word(24'($urandom()), 1'b0, -1);
        gap(T_RESET);

        // Reset in the middle of a word
        send_word(24'($urandom()), 1'b0, -1);
        send_bits(20);
        do_reset(3);
        gap(T_RESET);
        send_word(24'($urandom()), 1'b0, -1);
        gap(T_RESET);

`ifdef WS2812_RX_GLITCH_FILTER_EN
        send_word(24'hA5C30F, 1'b1, 10);
        send_word(24'h5A3CF0, 1'b1, 3);
        gap(T_RESET);
`endif

        for (int f = 0; f < 3; f++) begin
            n = int'($urandom_range(NUM_LEDS + 2, 1));
            for (int i = 0; i < n; i++) begin
                w = 24'($urandom());
                send_word(w, 1'b0, -1);
            end
            gap(T_RESET);
        end

        repeat (20) @(negedge clk);
        chk("events_pending", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
